// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants for the SPI register controller: register map, frame layout, FSM encoding.
package spi_reg_ctrl_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;

    localparam int unsigned FRAME_WR_BIT   = 15;
    localparam int unsigned FRAME_ADDR_MSB = 14;
    localparam int unsigned FRAME_ADDR_LSB = 8;
    localparam int unsigned FRAME_DATA_MSB = 7;
    localparam int unsigned FRAME_DATA_LSB = 0;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'd4;

    localparam int unsigned DEFAULT_MAX_ADDR = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Frame handshake between the SPI peripheral (master) and the register controller (slave).
interface spi_reg_ctrl_if;
    import spi_reg_ctrl_pkg::*;

    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_ready;

    modport master (output frame_valid, output frame_data, input frame_ready);
    modport slave  (input frame_valid, input frame_data, output frame_ready);

endinterface

// File: rtl/spi_reg_ctrl_frame_fifo.sv
// Pending-frame queue: power-of-two depth, pointers wrap naturally, occupancy counter gives full/empty.
module frame_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_MAX);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI register controller: queues incoming 16-bit frames, validates them and commits writes
// into five 8-bit control registers, counting rejected writes.
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ADDR   = DEFAULT_MAX_ADDR,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_reg_ctrl_if.slave        frame_if,
    output logic [DATA_W-1:0]    en_reg_out_7_0,
    output logic [DATA_W-1:0]    en_reg_out_15_8,
    output logic [DATA_W-1:0]    en_reg_pwm_7_0,
    output logic [DATA_W-1:0]    en_reg_pwm_15_8,
    output logic [DATA_W-1:0]    pwm_duty_cycle,
    output logic                 reg_update,
    output logic [7:0]           err_count,
    output logic                 busy
);

    localparam logic [ADDR_W-1:0] MAX_ADDR_A = ADDR_W'(MAX_ADDR);

    state_t              state;
    state_t              state_nxt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [FRAME_W-1:0]  fifo_dout;
    logic [FRAME_W-1:0]  frame_q;
    logic                frame_wr;
    logic [ADDR_W-1:0]   frame_addr;
    logic [DATA_W-1:0]   frame_byte;
    logic                addr_ok;
    logic                err_inc;

    assign frame_if.frame_ready = !fifo_full;
    assign fifo_push            = frame_if.frame_valid && !fifo_full;

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_frame_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (frame_if.frame_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign frame_wr   = frame_q[FRAME_WR_BIT];
    assign frame_addr = frame_q[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
    assign frame_byte = frame_q[FRAME_DATA_MSB:FRAME_DATA_LSB];
    assign addr_ok    = (frame_addr <= MAX_ADDR_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = fifo_empty ? ST_IDLE : ST_CHECK;
            ST_CHECK:  state_nxt = (frame_wr && addr_ok) ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = 1'b0;
        reg_update = 1'b0;
        err_inc    = 1'b0;
        case (state)
            ST_IDLE:   fifo_pop   = !fifo_empty;
            ST_CHECK:  err_inc    = frame_wr && !addr_ok;
            ST_COMMIT: reg_update = 1'b1;
            default:   ;
        endcase
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (fifo_pop) begin
            frame_q <= fifo_dout;
        end
    end

    // Register write lands on the edge that leaves COMMIT, one cycle after reg_update rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (reg_update) begin
            case (frame_addr)
                ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= frame_byte;
                ADDR_EN_OUT_15_8: en_reg_out_15_8 <= frame_byte;
                ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= frame_byte;
                ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= frame_byte;
                ADDR_PWM_DUTY:    pwm_duty_cycle  <= frame_byte;
                default:          ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level register model.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       reg_update;
    logic [7:0] err_count;
    logic       busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          saw_stall;

    bit          mon_en   = 1'b0;
    bit          mon_pend = 1'b0;
    logic [15:0] mon_e;
    logic [15:0] exp_q [$];

    spi_reg_ctrl_if frame_if ();

    spi_reg_ctrl #(
        .MAX_ADDR   (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_if        (frame_if),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .reg_update      (reg_update),
        .err_count       (err_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     frame;
        logic [4:0][7:0] regs;
        logic [7:0]      err;
        int unsigned     upd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_reg(input logic [6:0] a);
        case (a)
            7'd0:    return en_reg_out_7_0;
            7'd1:    return en_reg_out_15_8;
            7'd2:    return en_reg_pwm_7_0;
            7'd3:    return en_reg_pwm_15_8;
            7'd4:    return pwm_duty_cycle;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        frame_if.frame_valid = 1'b0;
        frame_if.frame_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present a frame and keep valid up until it is accepted; valid is left high.
    task automatic send_hold(input logic [15:0] f, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            frame_if.frame_valid = 1'b1;
            frame_if.frame_data  = f;
            if (frame_if.frame_ready) begin
                ok = 1'b1;
                break;
            end
            saw_stall = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else @(posedge clk);
    endtask

    task automatic send(input logic [15:0] f);
        bit ok;
        send_hold(f, ok);
        #1 frame_if.frame_valid = 1'b0;
    endtask

    task automatic wait_idle(output int unsigned pulses);
        bit done = 1'b0;
        pulses = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (reg_update) pulses++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Commit-order monitor: the negedge after a reg_update pulse must show the next expected write.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    check("commit_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit_order", 32'(get_reg(mon_e[14:8])), 32'(mon_e[7:0]));
                end
            end
            mon_pend = reg_update;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [10];
        int unsigned pulses;
        bit          ok;
        logic [7:0]  model_reg [5];
        int unsigned model_err;
        logic [15:0] f;
        logic [6:0]  a;
        logic [7:0]  d;

        tbl[0] = '{16'h857F, {8'h00, 8'h00, 8'h00, 8'h55, 8'h00}, 8'd1, 0};
        tbl[1] = '{16'h02AA, {8'h00, 8'h00, 8'h00, 8'h55, 8'h00}, 8'd1, 0};
        tbl[2] = '{16'h8011, {8'h00, 8'h00, 8'h00, 8'h55, 8'h11}, 8'd1, 1};
        tbl[3] = '{16'h84C0, {8'hC0, 8'h00, 8'h00, 8'h55, 8'h11}, 8'd1, 1};
        tbl[4] = '{16'h80FF, {8'hC0, 8'h00, 8'h00, 8'h55, 8'hFF}, 8'd1, 1};
        tbl[5] = '{16'h0412, {8'hC0, 8'h00, 8'h00, 8'h55, 8'hFF}, 8'd1, 0};
        tbl[6] = '{16'hFF00, {8'hC0, 8'h00, 8'h00, 8'h55, 8'hFF}, 8'd2, 0};
        tbl[7] = '{16'h83A5, {8'hC0, 8'hA5, 8'h00, 8'h55, 8'hFF}, 8'd2, 1};
        tbl[8] = '{16'h8266, {8'hC0, 8'hA5, 8'h66, 8'h55, 8'hFF}, 8'd2, 1};
        tbl[9] = '{16'h8100, {8'hC0, 8'hA5, 8'h66, 8'h00, 8'hFF}, 8'd2, 1};

        // Reset state
        do_reset();
        check("rst_ready", 32'(frame_if.frame_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_update", 32'(reg_update), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        for (int unsigned r = 0; r < 5; r++) check("rst_reg", 32'(get_reg(7'(r))), 32'd0);

        // Latency of a single write into an idle block
        send(16'h8155);
        @(negedge clk);
        @(negedge clk);
        check("lat_upd_n1", 32'(reg_update), 32'd0);
        @(negedge clk);
        check("lat_upd_n2", 32'(reg_update), 32'd1);
        check("lat_reg_n2", 32'(en_reg_out_15_8), 32'd0);
        @(negedge clk);
        check("lat_reg_n3", 32'(en_reg_out_15_8), 32'h55);
        check("lat_upd_n3", 32'(reg_update), 32'd0);
        for (int unsigned r = 0; r < 5; r++)
            if (r != 1) check("lat_other_reg", 32'(get_reg(7'(r))), 32'd0);

        // Directed table
        for (int unsigned i = 0; i < 10; i++) begin
            send(tbl[i].frame);
            wait_idle(pulses);
            for (int unsigned r = 0; r < 5; r++)
                check($sformatf("tbl%0d_reg%0d", i, r), 32'(get_reg(7'(r))), 32'(tbl[i].regs[r]));
            check($sformatf("tbl%0d_err", i), 32'(err_count), 32'(tbl[i].err));
            check($sformatf("tbl%0d_upd", i), pulses, tbl[i].upd);
        end

        // Back-to-back stream with valid held: queue must fill and order must hold
        do_reset();
        saw_stall = 1'b0;
        send_hold(16'h8011, ok);
        send_hold(16'h8122, ok);
        send_hold(16'h8233, ok);
        send_hold(16'h8344, ok);
        send_hold(16'h8480, ok);
        #1 frame_if.frame_valid = 1'b0;
        wait_idle(pulses);
        check("stream_stall_seen", 32'(saw_stall), 32'd1);
        check("stream_pulses", pulses, 32'd3);
        check("stream_r0", 32'(en_reg_out_7_0), 32'h11);
        check("stream_r1", 32'(en_reg_out_15_8), 32'h22);
        check("stream_r2", 32'(en_reg_pwm_7_0), 32'h33);
        check("stream_r3", 32'(en_reg_pwm_15_8), 32'h44);
        check("stream_r4", 32'(pwm_duty_cycle), 32'h80);

        // Error counter saturation
        do_reset();
        for (int unsigned i = 0; i < 255; i++) send_hold(16'h8500 | 16'(i & 8'hFF), ok);
        #1 frame_if.frame_valid = 1'b0;
        wait_idle(pulses);
        check("err_at_255", 32'(err_count), 32'd255);
        check("err_no_update", pulses, 32'd0);
        send(16'hFFFF);
        wait_idle(pulses);
        check("err_no_wrap", 32'(err_count), 32'd255);

        // Reset during COMMIT, with a second frame still queued
        do_reset();
        send(16'h84C0);
        send(16'h8011);
        @(negedge clk);
        @(negedge clk);
        check("midc_in_commit", 32'(reg_update), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midc_pwm", 32'(pwm_duty_cycle), 32'd0);
        check("midc_ready", 32'(frame_if.frame_ready), 32'd1);
        check("midc_busy", 32'(busy), 32'd0);
        check("midc_upd", 32'(reg_update), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midc_pwm_after", 32'(pwm_duty_cycle), 32'd0);
        check("midc_dropped", 32'(en_reg_out_7_0), 32'd0);
        check("midc_busy_after", 32'(busy), 32'd0);

        // Randomized traffic against the register model
        do_reset();
        for (int unsigned r = 0; r < 5; r++) model_reg[r] = 8'h00;
        model_err = 0;
        exp_q.delete();
        mon_pend = 1'b0;
        mon_en   = 1'b1;
        for (int unsigned i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 5));
            d = 8'($urandom);
            f = {($urandom_range(0, 3) != 0), a, d};
            send_hold(f, ok);
            if (ok) begin
                if (f[15]) begin
                    if (a <= 7'd4) begin
                        model_reg[a] = d;
                        exp_q.push_back(f);
                    end else if (model_err < 255) begin
                        model_err++;
                    end
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                #1 frame_if.frame_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        #1 frame_if.frame_valid = 1'b0;
        wait_idle(pulses);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        for (int unsigned r = 0; r < 5; r++)
            check($sformatf("rand_reg%0d", r), 32'(get_reg(7'(r))), 32'(model_reg[r]));
        check("rand_err", 32'(err_count), model_err);
        check("rand_all_committed", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
